// File: rtl/sum_accumulator.sv
// Sequential front/back-end for the external 32-bit carry-lookahead adder: streams N operands
// through the adder against a running total. Optional macro SUM_SATURATE_EN clamps the total on overflow.
module sum_accumulator #(
  parameter int unsigned CNT_W    = 8,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_c_in,
  input  logic [31:0]      add_s,
  input  logic             add_g,
  input  logic             add_p,
  output logic [31:0]      result,
  output logic             carry,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      acc, acc_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             carry_q, carry_nxt;
  logic             cout;
  logic [31:0]      beat_sum;

  // The adder is combinational and outside this block: feed it the total and the live operand.
  assign add_a    = acc;
  assign add_b    = in_data;
  assign add_c_in = 1'b0;
  assign cout     = add_g | (add_p & add_c_in);

`ifdef SUM_SATURATE_EN
  // Once any beat has overflowed, the total stays pinned at all-ones for the rest of the run.
  assign beat_sum = (cout || carry_q) ? 32'hFFFF_FFFF : add_s;
`else
  assign beat_sum = add_s;
`endif

  assign result = acc;
  assign carry  = carry_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= INIT_VAL;
      remaining <= '0;
      carry_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      carry_q   <= carry_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    carry_nxt     = carry_q;
    in_ready      = 1'b0;
    result_valid  = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt       = INIT_VAL;
          carry_nxt     = 1'b0;
          remaining_nxt = count;
          state_nxt     = (count == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          acc_nxt       = beat_sum;
          carry_nxt     = carry_q | cout;
          remaining_nxt = remaining - 1'b1;
          if (remaining == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        busy         = 1'b1;
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: behavioural adder model plus a queue of expected results.
module tb_sum_accumulator;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      add_a, add_b, add_s;
  logic             add_c_in, add_g, add_p;
  logic [31:0]      result;
  logic             carry, result_valid, result_ready, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  sum_accumulator #(.CNT_W(CNT_W), .INIT_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
    .add_s(add_s), .add_g(add_g), .add_p(add_p),
    .result(result), .carry(carry), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  // Behavioural stand-in for the carry-lookahead adder board.
  assign {add_g, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_c_in};
  assign add_p = &(add_a ^ add_b);

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {carry, total} for a run of words starting from 0.
  function automatic logic [32:0] model(input logic [31:0] w[$]);
    logic [31:0] a = 32'h0;
    logic        c = 1'b0;
    logic [32:0] t;
    foreach (w[i]) begin
      t = {1'b0, a} + {1'b0, w[i]};
      if (t[32]) c = 1'b1;
`ifdef SUM_SATURATE_EN
      a = c ? 32'hFFFF_FFFF : t[31:0];
`else
      a = t[31:0];
`endif
    end
    return {c, a};
  endfunction

  task automatic launch(input int cnt);
    start = 1'b1;
    count = CNT_W'(cnt);
    step();
    start = 1'b0;
  endtask

  // Drive words with an in_valid pattern; a 1 consumes the next word.
  task automatic stream(input logic [31:0] w[$], input bit pat[$]);
    int idx = 0;
    foreach (pat[i]) begin
      in_valid = pat[i];
      in_data  = pat[i] ? w[idx] : 32'hDEAD_BEEF;
      step();
      if (pat[i]) idx++;
    end
    in_valid = 1'b0;
  endtask

  // Wait for the result, hold it off for `hold` cycles, pop the scoreboard and handshake.
  task automatic drain(input string name, input int hold);
    int waited = 0;
    logic [32:0] exp;
    while (!result_valid && waited < 20) begin
      step();
      waited++;
    end
    n_cmp++;
    if (result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: result_valid=%b required 1", name, result_valid);
      return;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
    for (int h = 0; h <= hold; h++) begin
      n_cmp++;
      if (result !== exp[31:0] || carry !== exp[32] || result_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s hold%0d: result=%h carry=%b valid=%b required result=%h carry=%b valid=1",
                 name, h, result, carry, result_valid, exp[31:0], exp[32]);
      end
      if (h < hold) step();
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s release: valid=%b busy=%b required 0/0", name, result_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0; result_ready = 1'b0;
    step();
    n_cmp++;
    if ({in_ready, result_valid, busy, carry} !== 4'b0000 || result !== 32'h0) begin
      n_err++;
      $display("FAIL reset: rdy=%b val=%b busy=%b carry=%b result=%h required 0/0/0/0/0",
               in_ready, result_valid, busy, carry, result);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    exp_q.push_back(model('{32'd1, 32'd2, 32'd3}));
    launch(3);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || add_c_in !== 1'b0) begin
      n_err++;
      $display("FAIL basic accum: rdy=%b busy=%b cin=%b required 1/1/0", in_ready, busy, add_c_in);
    end
    stream('{32'd1, 32'd2, 32'd3}, '{1, 1, 1});
    n_cmp++;
    if (result_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic latency: valid=%b rdy=%b required 1/0", result_valid, in_ready);
    end
    drain("basic", 0);
  endtask

  task automatic test_overflow();
    exp_q.push_back(model('{32'hFFFF_FFFF, 32'h0000_0002}));
    launch(2);
    stream('{32'hFFFF_FFFF, 32'h0000_0002}, '{1, 1});
    drain("overflow", 1);
  endtask

  task automatic test_zero_count();
    exp_q.push_back(33'h0);
    launch(0);
    n_cmp++;
    if (result_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_count: valid=%b rdy=%b busy=%b required 1/0/1", result_valid, in_ready, busy);
    end
    drain("zero_count", 0);
  endtask

  task automatic test_gapped();
    exp_q.push_back(model('{32'd10, 32'd20, 32'd30, 32'd40}));
    launch(4);
    stream('{32'd10, 32'd20, 32'd30, 32'd40}, '{1, 0, 1, 0, 1, 1});
    drain("gapped", 5);
  endtask

  task automatic test_reset_midrun();
    launch(4);
    stream('{32'd100, 32'd200}, '{1, 1});
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, result_valid, busy, carry} !== 4'b0000 || result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_midrun: rdy=%b val=%b busy=%b carry=%b result=%h required 0/0/0/0/0",
               in_ready, result_valid, busy, carry, result);
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midrun idle: busy=%b valid=%b required 0/0", busy, result_valid);
    end
    exp_q.push_back(model('{32'd7}));
    launch(1);
    stream('{32'd7}, '{1});
    drain("fresh_run", 0);
  endtask

  task automatic test_ignored_controls();
    exp_q.push_back(model('{32'd5, 32'd6}));
    launch(2);
    start = 1'b1; count = CNT_W'(9); result_ready = 1'b1;
    step();
    start = 1'b0; result_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0 || result !== 32'h0) begin
      n_err++;
      $display("FAIL ignore_accum: rdy=%b valid=%b result=%h required 1/0/0", in_ready, result_valid, result);
    end
    stream('{32'd5, 32'd6}, '{1, 1});
    start = 1'b1; count = CNT_W'(0);
    step();
    n_cmp++;
    if (result_valid !== 1'b1 || result !== 32'd11) begin
      n_err++;
      $display("FAIL ignore_done: valid=%b result=%h required 1/0000000b", result_valid, result);
    end
    // start stays high through the handshake; it must not be sampled in DONE.
    drain("ignore_controls", 0);
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero_count();
    test_gapped();
    test_reset_midrun();
    test_ignored_controls();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d results left over, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
